// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter that serialises single-beat commands from NUM_REQ requesters onto one AXI4-Lite master port.
// Optional build macro AXI_ARB_RANGE_CHECK_EN answers commands at or above ADDR_LIMIT locally with DECERR.
module axi4_lite_req_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_LIMIT    = 32
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]     req_wstrb,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic [ADDRESS_WIDTH-1:0]            M_AXI_AWADDR,
    output logic                                M_AXI_AWVALID,
    input  logic                                M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]               M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]             M_AXI_WSTRB,
    output logic                                M_AXI_WVALID,
    input  logic                                M_AXI_WREADY,
    input  logic [1:0]                          M_AXI_BRESP,
    input  logic                                M_AXI_BVALID,
    output logic                                M_AXI_BREADY,
    output logic [ADDRESS_WIDTH-1:0]            M_AXI_ARADDR,
    output logic                                M_AXI_ARVALID,
    input  logic                                M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]               M_AXI_RDATA,
    input  logic [1:0]                          M_AXI_RRESP,
    input  logic                                M_AXI_RVALID,
    output logic                                M_AXI_RREADY
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] LIMIT = ADDRESS_WIDTH'(ADDR_LIMIT);
`ifdef AXI_ARB_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

    state_t                    state, state_next;
    logic [IW-1:0]             ptr;
    logic [IW-1:0]             sel;
    logic [IW-1:0]             idx;
    logic                      sel_found;
    logic                      accept;
    logic                      sel_oor;
    logic [ADDRESS_WIDTH-1:0]  sel_addr;
    logic [ADDRESS_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]     lat_wdata;
    logic [SW-1:0]             lat_wstrb;
    logic                      aw_done, w_done;
    logic                      aw_fire, w_fire;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;
    logic [1:0]                rsp_resp_q;

    // Search downward so the last hit is the closest requester after the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        idx       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    assign accept   = (state == IDLE) && sel_found;
    assign sel_addr = req_addr[int'(sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign sel_oor  = RANGE_EN && (sel_addr >= LIMIT);
    assign aw_fire  = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_fire   = M_AXI_WVALID && M_AXI_WREADY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                state_next = IDLE;
                if (sel_found) begin
                    if (sel_oor)             state_next = RESP;
                    else if (req_write[sel]) state_next = WR_REQ;
                    else                     state_next = RD_REQ;
                end
            end
            WR_REQ:  state_next = ((aw_done || aw_fire) && (w_done || w_fire)) ? WR_RESP : WR_REQ;
            WR_RESP: state_next = M_AXI_BVALID ? RESP : WR_RESP;
            RD_REQ:  state_next = M_AXI_ARREADY ? RD_DATA : RD_REQ;
            RD_DATA: state_next = M_AXI_RVALID ? RESP : RD_DATA;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ptr doubles as the granted requester index for the whole transaction.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ptr         <= IW'(NUM_REQ - 1);
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_wstrb   <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            if (accept) begin
                ptr       <= sel;
                lat_addr  <= sel_addr;
                lat_wdata <= req_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                lat_wstrb <= req_wstrb[int'(sel)*SW +: SW];
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                if (sel_oor) begin
                    rsp_rdata_q <= '0;
                    rsp_resp_q  <= 2'b11;
                end
            end
            if (state == WR_REQ) begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire)  w_done  <= 1'b1;
            end
            if ((state == WR_RESP) && M_AXI_BVALID) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= M_AXI_BRESP;
            end
            if ((state == RD_DATA) && M_AXI_RVALID) begin
                rsp_rdata_q <= M_AXI_RDATA;
                rsp_resp_q  <= M_AXI_RRESP;
            end
        end
    end

    // Handshakes: a transfer happens on a rising ACLK edge where valid and ready are
    // both high; a raised valid and its payload stay put until that edge.
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_rdata     = '0;
        rsp_resp      = 2'b00;
        M_AXI_AWADDR  = lat_addr;
        M_AXI_ARADDR  = lat_addr;
        M_AXI_WDATA   = lat_wdata;
        M_AXI_WSTRB   = lat_wstrb;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        if (ARESETN && accept) req_ready[sel] = 1'b1;
        case (state)
            WR_REQ: begin
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
            end
            WR_RESP: M_AXI_BREADY  = 1'b1;
            RD_REQ:  M_AXI_ARVALID = 1'b1;
            RD_DATA: M_AXI_RREADY  = 1'b1;
            RESP: begin
                rsp_valid[ptr] = 1'b1;
                rsp_rdata      = rsp_rdata_q;
                rsp_resp       = rsp_resp_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed bench for axi4_lite_req_arbiter: command table plus round-robin, AR-stall and mid-write reset sequences.
// Builds with or without AXI_ARB_RANGE_CHECK_EN; expectations follow the macro.
module tb_axi4_lite_req_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AXI_ARB_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic              aclk, aresetn;
    logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*4-1:0]   req_wstrb;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [AW-1:0]     awaddr, araddr;
    logic [DW-1:0]     wdata, rdata;
    logic [3:0]        wstrb;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [1:0]        bresp, rresp;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int          id_q[$];

    axi4_lite_req_arbiter #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LIMIT(32)) dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // ---------------- clock / reset ----------------
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        aresetn   = 1'b0;
        req_valid = '0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // ---------------- AXI slave model (64-word memory) ----------------
    logic [31:0] mem [64];
    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    int aw_cnt, w_cnt, ar_cnt;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_have, w_have;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
        {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} = '0;
        {aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_have, w_have} = '0;
        {aw_cnt, w_cnt, ar_cnt} = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} = '0;
                {aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_have, w_have} = '0;
                {aw_cnt, w_cnt, ar_cnt} = '0;
            end else begin
                if (b_hs) bvalid = 1'b0;
                if (r_hs) rvalid = 1'b0;
                if (aw_hs) aw_have = 1'b1;
                if (w_hs)  w_have  = 1'b1;
                if (ar_hs) begin
                    rvalid = 1'b1;
                    rdata  = mem[s_araddr[5:0]];
                    rresp  = (s_araddr == 32'd30) ? 2'b10 : 2'b00;
                end
                if (aw_have && w_have && !bvalid) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr[5:0]][b*8 +: 8] = s_wdata[b*8 +: 8];
                    bvalid  = 1'b1;
                    bresp   = (s_awaddr == 32'd30) ? 2'b10 : 2'b00;
                    aw_have = 1'b0;
                    w_have  = 1'b0;
                end
                awready = awvalid && !aw_have && (aw_cnt >= aw_delay);
                if (!awvalid) aw_cnt = 0; else if (!awready) aw_cnt++;
                wready = wvalid && !w_have && (w_cnt >= w_delay);
                if (!wvalid) w_cnt = 0; else if (!wready) w_cnt++;
                arready = arvalid && (ar_cnt >= ar_delay);
                if (!arvalid) ar_cnt = 0; else if (!arready) ar_cnt++;
                aw_hs = awvalid && awready;
                if (aw_hs) s_awaddr = awaddr;
                w_hs = wvalid && wready;
                if (w_hs) begin s_wdata = wdata; s_wstrb = wstrb; end
                ar_hs = arvalid && arready;
                if (ar_hs) s_araddr = araddr;
                b_hs = bvalid && bready;
                r_hs = rvalid && rready;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    logic prev_aw = 1'b0, prev_w = 1'b0;
    initial begin
        forever begin
            @(negedge aclk);
            #4;
            if (aresetn) begin
                if (awvalid && !prev_aw) check("aw_w_rise_together", {wvalid, prev_w}, 2'b10);
                if (req_ready != '0) check("req_ready_onehot", 128'($onehot(req_ready)), 1);
                if (rsp_valid != '0) check("rsp_valid_onehot", 128'($onehot(rsp_valid)), 1);
            end
            prev_aw = awvalid;
            prev_w  = wvalid;
        end
    end

    // ---------------- driver ----------------
    task automatic do_cmd(input int id, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input bit oor,
                          output logic [31:0] got_rdata, output logic [1:0] got_resp);
        int n;
        bit got;
        got_rdata = 'x;
        got_resp  = 'x;
        @(negedge aclk);
        req_write[id]          = wr;
        req_addr[id*AW +: AW]  = addr;
        req_wdata[id*DW +: DW] = wd;
        req_wstrb[id*4 +: 4]   = strb;
        req_valid[id]          = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 50) begin @(negedge aclk); #1; n++; end
        if (!req_ready[id]) begin
            check("accept_timeout", 0, 1);
            req_valid[id] = 1'b0;
            return;
        end
        check("accept_grant", req_ready, NR'(1) << id);
        @(negedge aclk);
        #1;
        req_valid[id] = 1'b0;
        if (oor) begin
            check("oor_no_axi", {awvalid, wvalid, arvalid}, 3'b000);
            check("oor_rsp_next_cycle", rsp_valid, NR'(1) << id);
        end else if (wr) begin
            check("aw_w_first_cycle", {awvalid, wvalid, awaddr, wdata, wstrb}, {2'b11, addr, wd, strb});
        end else begin
            check("ar_first_cycle", {arvalid, araddr}, {1'b1, addr});
        end
        got = 1'b0;
        n   = 0;
        while (n < 60) begin
            if (rsp_valid != '0) begin got = 1'b1; break; end
            @(negedge aclk);
            #1;
            n++;
        end
        if (!got) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("rsp_id", rsp_valid, NR'(1) << id);
        got_rdata = rsp_rdata;
        got_resp  = rsp_resp;
        @(negedge aclk);
        #1;
        check("rsp_single_pulse", {rsp_valid, rsp_rdata}, '0);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int          id;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] r;
        logic [1:0]  rs;
        int n, n_rsp, ar_cycles, exp_id;

        vecs[0]  = '{0, 1, 32'd3,  32'hDEADBEEF, 4'hF, 32'h0, 2'b00};
        vecs[1]  = '{0, 0, 32'd3,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{1, 1, 32'd5,  32'h11223344, 4'hF, 32'h0, 2'b00};
        vecs[3]  = '{1, 1, 32'd5,  32'hAABBCCDD, 4'h5, 32'h0, 2'b00};
        vecs[4]  = '{0, 0, 32'd5,  32'h0,        4'h0, 32'h11BB33DD, 2'b00};
        vecs[5]  = '{1, 0, 32'd40, 32'h0,        4'h0, RANGE_EN ? 32'h0 : 32'hA5000028, RANGE_EN ? 2'b11 : 2'b00};
        vecs[6]  = '{1, 1, 32'd33, 32'h12345678, 4'hF, 32'h0, RANGE_EN ? 2'b11 : 2'b00};
        vecs[7]  = '{0, 0, 32'd33, 32'h0,        4'h0, RANGE_EN ? 32'hA5000021 : 32'h12345678, 2'b00};
        vecs[8]  = '{1, 0, 32'd31, 32'h0,        4'h0, 32'hA500001F, 2'b00};
        vecs[9]  = '{0, 1, 32'd30, 32'hCAFEF00D, 4'h3, 32'h0, 2'b10};
        vecs[10] = '{1, 0, 32'd30, 32'h0,        4'h0, 32'hA500F00D, 2'b10};
        vecs[11] = '{0, 0, 32'd32, 32'h0,        4'h0, RANGE_EN ? 32'h0 : 32'hA5000020, RANGE_EN ? 2'b11 : 2'b00};

        aresetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        @(negedge aclk);
        req_valid = 2'b11;
        #1;
        check("reset_outputs", {req_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready,
                                awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp}, '0);
        req_valid = '0;
        apply_reset();

        // Command table: writes, reads, byte strobes, error responses, address-limit boundary.
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(vecs[i].exp_rdata);
            do_cmd(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].strb,
                   RANGE_EN && (vecs[i].addr >= 32'd32), r, rs);
            check($sformatf("vec%0d_rdata", i), r, exp_q.pop_front());
            check($sformatf("vec%0d_resp", i), rs, vecs[i].exp_resp);
        end

        // Round robin with both requesters held valid after reset.
        apply_reset();
        id_q = '{0, 1, 0, 1};
        @(negedge aclk);
        req_write = 2'b00;
        req_addr  = {32'd5, 32'd3};
        req_valid = 2'b11;
        n = 0;
        n_rsp = 0;
        while (n_rsp < 4 && n < 200) begin
            #1;
            if (req_ready != '0) begin
                if (id_q.size() == 0) begin
                    check("rr_extra_grant", req_ready, 0);
                end else begin
                    exp_id = id_q.pop_front();
                    check("rr_grant_order", req_ready, NR'(1) << exp_id);
                    exp_q.push_back(exp_id == 0 ? 32'hDEADBEEF : 32'h11BB33DD);
                end
            end
            if (rsp_valid != '0) begin
                n_rsp++;
                if (exp_q.size() == 0) check("rr_extra_rsp", rsp_valid, 0);
                else check("rr_rdata", rsp_rdata, exp_q.pop_front());
                if (n_rsp == 4) req_valid = '0;
            end
            @(negedge aclk);
            n++;
        end
        check("rr_rsp_count", n_rsp, 4);
        check("rr_grants_left", id_q.size(), 0);

        // ARREADY held low: ARVALID/ARADDR stable, other requester blocked until RESP ends.
        ar_delay = 5;
        @(negedge aclk);
        req_write[0]     = 1'b0;
        req_addr[0 +: AW] = 32'd7;
        req_valid        = 2'b01;
        #1;
        check("stall_accept", req_ready, 2'b01);
        @(negedge aclk);
        #1;
        req_write[1]        = 1'b1;
        req_addr[AW +: AW]  = 32'd9;
        req_wdata[DW +: DW] = 32'h0000_0055;
        req_wstrb[4 +: 4]   = 4'hF;
        req_valid           = 2'b10;
        ar_cycles = 0;
        n = 0;
        while (!rsp_valid[0] && n < 50) begin
            if (arvalid) begin
                ar_cycles++;
                check("stall_araddr", araddr, 32'd7);
            end
            check("stall_blocks_req1", req_ready, 2'b00);
            @(negedge aclk);
            #1;
            n++;
        end
        check("stall_arvalid_cycles", ar_cycles, 6);
        check("stall_rsp", {rsp_valid, rsp_rdata, rsp_resp, req_ready}, {2'b01, 32'hA5000007, 2'b00, 2'b00});
        ar_delay = 0;
        @(negedge aclk);
        #1;
        check("stall_req1_after_resp", req_ready, 2'b10);
        @(negedge aclk);
        req_valid = '0;
        n = 0;
        while (!rsp_valid[1] && n < 50) begin @(negedge aclk); #1; n++; end
        check("stall_req1_done", {rsp_valid, rsp_resp}, {2'b10, 2'b00});

        // Reset in the middle of a write with AWVALID high.
        aw_delay = 10;
        @(negedge aclk);
        req_write          = 2'b11;
        req_addr[0 +: AW]  = 32'd12;
        req_valid          = 2'b01;
        @(negedge aclk);
        #1;
        req_valid = 2'b10;
        check("rst_aw_active", awvalid, 1'b1);
        @(negedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        check("rst_async_outputs", {req_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready,
                                    awaddr, wdata, wstrb, rsp_rdata, rsp_resp}, '0);
        repeat (2) @(negedge aclk);
        aresetn   = 1'b1;
        aw_delay  = 0;
        req_write = 2'b00;
        req_valid = 2'b11;
        #1;
        check("rst_first_grant_req0", req_ready, 2'b01);
        req_valid = '0;
        repeat (2) @(negedge aclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_lite_req_arbiter.md
Name: axi4_lite_req_arbiter

Overview:
Round-robin arbiter and transaction sequencer that lets NUM_REQ simple command requesters share one AXI4-Lite slave, such as the memory-backed register slave.
- Each requester issues a single-beat read or write command.
- The block grants one requester at a time, drives the full AXI4-Lite master handshake, then returns the response to the granted requester.
- Exactly one transaction is outstanding at any time.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDRESS_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (multiple of 8)
ADDR_LIMIT, 32, first illegal address; used only with the optional feature

Ports:
ACLK  in  1  clock
ARESETN  in  1  async active-low reset
req_valid  in  NUM_REQ  command valid, one bit per requester
req_ready  out  NUM_REQ  command accepted (one-hot, one-cycle pulse)
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses, requester i at [i*AW +: AW]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes
rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to the granted requester
rsp_rdata  out  DATA_WIDTH  read data (shared); 0 for writes
rsp_resp  out  2  RRESP/BRESP (shared)
M_AXI_AWADDR / M_AXI_AWVALID / M_AXI_AWREADY  out / out / in  AW / 1 / 1  write address channel
M_AXI_WDATA / M_AXI_WSTRB / M_AXI_WVALID / M_AXI_WREADY  out / out / out / in  DW / DW/8 / 1 / 1  write data channel
M_AXI_BRESP / M_AXI_BVALID / M_AXI_BREADY  in / in / out  2 / 1 / 1  write response channel
M_AXI_ARADDR / M_AXI_ARVALID / M_AXI_ARREADY  out / out / in  AW / 1 / 1  read address channel
M_AXI_RDATA / M_AXI_RRESP / M_AXI_RVALID / M_AXI_RREADY  in / in / in / out  DW / 2 / 1 / 1  read data channel

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - All outputs 0; state IDLE.
  - Last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- IDLE:
  - Grant g = first i with req_valid[i] set, searching from pointer+1 modulo NUM_REQ.
  - req_ready[g] is combinational, high only in IDLE while req_valid[g]=1.
  - At the accept edge: latch write/addr/wdata/wstrb of g, set pointer=g, go to WR_REQ or RD_REQ.
- WR_REQ:
  - AWVALID and WVALID both assert in the first cycle after accept, with AWADDR/WDATA/WSTRB held stable.
  - Each valid drops independently after its own handshake.
  - Once both handshakes are complete, go to WR_RESP. If both complete in the same cycle, transition directly.
- WR_RESP: BREADY=1; on BVALID, capture BRESP and go to RESP.
- RD_REQ: ARVALID=1 with ARADDR stable until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1; on RVALID, capture RDATA/RRESP and go to RESP.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle with rsp_rdata/rsp_resp valid; otherwise rsp_rdata=0.
  - Next state IDLE. The requester cannot stall the response.
- Latency, slave responding with zero wait: accept at T, AXI valid at T+1, rsp_valid at handshake cycle + 1.
- No new grant while not IDLE. A requester dropping req_valid before grant is simply skipped.
- Unknown state decodes to IDLE.

Optional Feature:
Macro AXI_ARB_RANGE_CHECK_EN.
- Defined:
  - A command with addr >= ADDR_LIMIT is accepted normally but produces no AXI activity.
  - The FSM goes IDLE to RESP, so rsp_valid pulses one cycle after accept with rsp_resp=2'b11 (DECERR) and rsp_rdata=0.
  - This also applies to writes.
- Undefined: every address is forwarded and ADDR_LIMIT is ignored.

Test Plan:
1. Requester 0 writes addr 3, data 0xDEADBEEF, wstrb 4'hF; then reads addr 3 -> AW and W asserted together; rsp_valid[0] pulses with resp 2'b00; read returns rsp_rdata 0xDEADBEEF.
2. Write 0x11223344 to addr 5, then write 0xAABBCCDD with wstrb 4'b0101 -> read of addr 5 returns 0x11BB33DD.
3. req_valid=2'b11 held for four commands after reset -> grant order 0,1,0,1; req_ready is never high on both bits; exactly one rsp_valid pulse per command.
4. Slave holds ARREADY low 5 cycles -> ARVALID stays 1 and ARADDR stays stable; req_ready stays 0 for requester 1 until RESP completes.
5. ARESETN asserted while AWVALID=1 -> all AXI valids and req_ready drop in the same cycle; after release, simultaneous requests grant requester 0 first.
6. With AXI_ARB_RANGE_CHECK_EN and ADDR_LIMIT=32, read addr 40 -> no ARVALID; rsp_resp 2'b11 one cycle after accept. Without the macro -> ARVALID with ARADDR 40.
